// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller; drives the pipeline stall line.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int TAG_W     = 32 - 5 - IDX_W;
  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t state_q, state_d;

  logic [LINE_BITS-1:0] data_arr [NUM_LINES];
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, dirty_q;

  // Miss address captured at miss start so WB/FILL do not depend on the CPU bus.
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;

  logic [TAG_W-1:0]     tag;
  logic [IDX_W-1:0]     idx;
  logic [2:0]           word;
  logic [LINE_BITS-1:0] line_rd;
  logic                 hit, serving, access_ok, word_wr, start_miss, fill_done;
  logic                 unused_addr_bits;

  assign tag  = cpu_addr_i[31 -: TAG_W];
  assign idx  = cpu_addr_i[5 +: IDX_W];
  assign word = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit        = valid_q[idx] && (tag_arr[idx] == tag);
  // DONE re-evaluates the access against the freshly installed line.
  assign serving    = ((state_q == IDLE) || (state_q == DONE)) && hit;
  assign stall_o    = cpu_req_i && !serving;
  assign access_ok  = cpu_req_i && serving;
  assign word_wr    = access_ok && cpu_we_i;
  assign start_miss = (state_q == IDLE) && cpu_req_i && !hit;
  assign fill_done  = (state_q == FILL) && mem_ack_i;

  assign line_rd    = data_arr[idx];
  assign cpu_data_o = access_ok ? line_rd[{word, 5'b0} +: 32] : 32'h0;

  // NOTE: every output and next-state variable gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_data_o = '0;
    case (state_q)
      IDLE: begin
        if (start_miss) state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
      end
      WB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_arr[miss_idx_q], miss_idx_q, 5'b0};
        mem_data_o = data_arr[miss_idx_q];
        if (mem_ack_i) state_d = FILL;
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, miss_idx_q, 5'b0};
        if (mem_ack_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        miss_tag_q <= tag;
        miss_idx_q <= idx;
      end
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (word_wr) dirty_q[idx] <= 1'b1;
    end
  end

  // NOTE: line and tag storage are not reset; valid_q gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_arr[miss_idx_q] <= mem_data_i;
      tag_arr[miss_idx_q]  <= miss_tag_q;
    end
    if (word_wr) data_arr[idx][{word, 5'b0} +: 32] <= cpu_data_i;
  end

`ifdef DCACHE_STATS_EN
  // Only first-time IDLE hits count; DONE completions belong to the miss.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= 32'h0;
      miss_cnt_o <= 32'h0;
    end else begin
      if ((state_q == IDLE) && access_ok) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (start_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
